// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single 256-bit off-chip data-memory port between the
// instruction-cache controller (port I) and the data-cache controller
// (port D). Arbitration is round-robin with a registered grant. The
// winner's write flag, address and write line are latched on the grant
// edge and held until the memory acks.
//
// Handshake: a requester raises x_enable_i with its command. The command is
// sampled only in the IDLE cycle in which the grant is decided. Any later
// change on the requester inputs is ignored. The transaction ends on the
// single-cycle mem_ack_i pulse. That same cycle, x_ack_o is 1 for the granted
// requester only, and the requester qualifies x_data_o with it. Every
// transaction is followed by one IDLE turnaround cycle with mem_enable_o = 0.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   i_* / d_*               requester command inputs, read line, ack pulse
//   mem_*                   memory command outputs, read line, ack input
//   busy_o                  a grant is active
//   timeout_o               sticky: a grant went TIMEOUT cycles without ack
//   stray_ack_o             sticky: mem_ack_i seen while IDLE
//   state_o                 debug view of the FSM state (0 IDLE, 1 I, 2 D)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_enable_i,
  input  logic         i_write_i,
  input  logic [31:0]  i_addr_i,
  input  logic [255:0] i_data_i,
  output logic [255:0] i_data_o,
  output logic         i_ack_o,
  input  logic         d_enable_i,
  input  logic         d_write_i,
  input  logic [31:0]  d_addr_i,
  input  logic [255:0] d_data_i,
  output logic [255:0] d_data_o,
  output logic         d_ack_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic         busy_o,
  output logic         timeout_o,
  output logic         stray_ack_o,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             last_d_q;      // 1: D was granted last, so I wins a tie
  logic             grant_i, grant_d, done;
  logic             in_grant;
  logic [CNT_W-1:0] cnt_q, cnt_inc;

  // Next-state logic. The grant decision is made in IDLE only, so the
  // turnaround cycle after every ack comes out of the state encoding itself.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable_i && (!d_enable_i || last_d_q)) begin
          state_d = GRANT_I;
          grant_i = 1'b1;
        end else if (d_enable_i) begin
          state_d = GRANT_D;
          grant_d = 1'b1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_grant = (state_q != IDLE);
  // The counter saturates so that a grant that hangs for ever cannot wrap it.
  assign cnt_inc  = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= '0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      timeout_o   <= 1'b0;
      stray_ack_o <= 1'b0;
    end else begin
      state_q <= state_d;

      if (grant_i) begin
        mem_write_o <= i_write_i;
        mem_addr_o  <= i_addr_i;
        mem_data_o  <= i_data_i;
      end else if (grant_d) begin
        mem_write_o <= d_write_i;
        mem_addr_o  <= d_addr_i;
        mem_data_o  <= d_data_i;
      end

      if (done) begin
        last_d_q <= (state_q == GRANT_D);
      end

      if (in_grant && !mem_ack_i) begin
        cnt_q <= cnt_inc;
        if (cnt_inc == TIMEOUT_C) begin
          timeout_o <= 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end

      if (!in_grant && mem_ack_i) begin
        stray_ack_o <= 1'b1;
      end
    end
  end

  assign mem_enable_o = in_grant;
  assign busy_o       = in_grant;
  assign state_o      = state_q;

  // An ack that arrives in a reset cycle is dropped, so the acks are also
  // gated by rst_i.
  assign i_ack_o = (state_q == GRANT_I) && mem_ack_i && !rst_i;
  assign d_ack_o = (state_q == GRANT_D) && mem_ack_i && !rst_i;

  assign i_data_o = mem_data_i;
  assign d_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter, built with TIMEOUT = 15 and CNT_W = 4 so
// that the watchdog can be reached quickly. Each scenario task drives its
// own stimulus and checks the DUT outputs. Inputs change 1 ns after the
// rising edge, and outputs are sampled 1 ns after that.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;

  logic         clk;
  logic         rst;
  logic         i_enable, i_write, i_ack;
  logic [31:0]  i_addr;
  logic [255:0] i_wdata, i_rdata;
  logic         d_enable, d_write, d_ack;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata, d_rdata;
  logic [255:0] mem_rdata, mem_wdata;
  logic         mem_ack, mem_enable, mem_write;
  logic [31:0]  mem_addr;
  logic         busy, timeout, stray_ack;
  logic [1:0]   state;

  int checks;
  int errors;

  logic [31:0] exp_q[$];

  mem_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .i_enable_i   (i_enable),
    .i_write_i    (i_write),
    .i_addr_i     (i_addr),
    .i_data_i     (i_wdata),
    .i_data_o     (i_rdata),
    .i_ack_o      (i_ack),
    .d_enable_i   (d_enable),
    .d_write_i    (d_write),
    .d_addr_i     (d_addr),
    .d_data_i     (d_wdata),
    .d_data_o     (d_rdata),
    .d_ack_o      (d_ack),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack),
    .mem_data_o   (mem_wdata),
    .mem_addr_o   (mem_addr),
    .mem_enable_o (mem_enable),
    .mem_write_o  (mem_write),
    .busy_o       (busy),
    .timeout_o    (timeout),
    .stray_ack_o  (stray_ack),
    .state_o      (state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    i_enable  = 1'b0;
    i_write   = 1'b0;
    i_addr    = '0;
    i_wdata   = '0;
    d_enable  = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scenarios.
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE);
    end
    checks++;
    if ({mem_enable, mem_write, busy, timeout, stray_ack, i_ack, d_ack} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {mem_enable, mem_write, busy, timeout, stray_ack, i_ack, d_ack});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 256'h0) begin
      errors++;
      $display("FAIL reset_mem_regs: addr %h data %h expected 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single_read();
    logic [255:0] line;
    line = {8{32'hDEAD_0400}};
    do_reset();
    d_enable = 1'b1;
    d_write  = 1'b0;
    d_addr   = 32'h0000_0400;
    tick();
    d_enable = 1'b0;
    #1;
    checks++;
    if (mem_enable !== 1'b1 || mem_addr !== 32'h400 || mem_write !== 1'b0 || state !== S_GRANT_D) begin
      errors++;
      $display("FAIL read_grant: en %b addr %h wr %b state %0d expected 1 400 0 2",
               mem_enable, mem_addr, mem_write, state);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (mem_enable !== 1'b1 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
        errors++;
        $display("FAIL read_wait: cycle %0d en %b i_ack %b d_ack %b expected 1 0 0",
                 k, mem_enable, i_ack, d_ack);
      end
    end
    tick();
    mem_rdata = line;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== line) begin
      errors++;
      $display("FAIL read_ack: d_ack %b i_ack %b d_data %h expected 1 0 %h",
               d_ack, i_ack, d_rdata, line);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_enable !== 1'b0 || d_ack !== 1'b0 || state !== S_IDLE) begin
      errors++;
      $display("FAIL read_after_ack: en %b d_ack %b state %0d expected 0 0 0",
               mem_enable, d_ack, state);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp;
    do_reset();
    i_addr   = 32'h0000_1000;
    d_addr   = 32'h0000_2000;
    i_enable = 1'b1;
    d_enable = 1'b1;
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h2000);
    tick();
    for (int g = 0; g < 4; g++) begin
      exp = exp_q.pop_front();
      #1;
      checks++;
      if (busy !== 1'b1 || mem_addr !== exp) begin
        errors++;
        $display("FAIL rr_grant: grant %0d busy %b addr %h expected 1 %h", g, busy, mem_addr, exp);
      end
      tick();
      mem_ack = 1'b1;
      #1;
      checks++;
      if ({i_ack, d_ack} !== ((exp == 32'h1000) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_ack: grant %0d acks %b expected %b", g, {i_ack, d_ack},
                 (exp == 32'h1000) ? 2'b10 : 2'b01);
      end
      tick();
      mem_ack = 1'b0;
      #1;
      checks++;
      if (mem_enable !== 1'b0 || state !== S_IDLE) begin
        errors++;
        $display("FAIL rr_turnaround: grant %0d en %b state %0d expected 0 0", g, mem_enable, state);
      end
      tick();
    end
    i_enable = 1'b0;
    d_enable = 1'b0;
  endtask

  task automatic test_write_hold();
    logic [255:0] pattern;
    pattern = {32{8'hA5}};
    do_reset();
    d_enable = 1'b1;
    d_write  = 1'b1;
    d_addr   = 32'h0000_0800;
    d_wdata  = pattern;
    tick();
    d_addr   = 32'h0;
    d_wdata  = '0;
    d_write  = 1'b0;
    d_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (mem_addr !== 32'h800 || mem_wdata !== pattern || mem_write !== 1'b1 || mem_enable !== 1'b1) begin
        errors++;
        $display("FAIL write_hold: cycle %0d addr %h wr %b en %b data %h expected 800 1 1 %h",
                 k, mem_addr, mem_write, mem_enable, mem_wdata, pattern);
      end
      tick();
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: d_ack %b i_ack %b expected 1 0", d_ack, i_ack);
    end
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    d_enable = 1'b1;
    d_write  = 1'b1;
    d_addr   = 32'h0000_0C00;
    d_wdata  = '1;
    tick();
    d_enable = 1'b0;
    tick();
    tick();
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (d_ack !== 1'b0 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack_drop: d_ack %b i_ack %b expected 0 0", d_ack, i_ack);
    end
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (state !== S_IDLE ||
        {mem_enable, mem_write, busy, timeout, stray_ack, i_ack, d_ack} !== 7'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 256'h0) begin
      errors++;
      $display("FAIL rst_mid_grant: state %0d flags %b addr %h data %h expected 0 0000000 0 0",
               state, {mem_enable, mem_write, busy, timeout, stray_ack, i_ack, d_ack},
               mem_addr, mem_wdata);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    d_enable = 1'b1;
    d_write  = 1'b0;
    d_addr   = 32'h0000_0040;
    tick();
    d_enable = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: after 14 grant cycles got %b expected 0", timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || mem_enable !== 1'b1 || state !== S_GRANT_D) begin
      errors++;
      $display("FAIL timeout_set: to %b en %b state %0d expected 1 1 2", timeout, mem_enable, state);
    end
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (mem_enable !== 1'b1 || mem_addr !== 32'h40 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: en %b addr %h to %b expected 1 40 1", mem_enable, mem_addr, timeout);
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (d_ack !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ack: d_ack %b expected 1", d_ack);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (state !== S_IDLE || timeout !== 1'b1 || mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: state %0d to %b en %b expected 0 1 0", state, timeout, mem_enable);
    end
  endtask

  task automatic test_stray_ack();
    do_reset();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (i_ack !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL stray_no_ack: i_ack %b d_ack %b expected 0 0", i_ack, d_ack);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (stray_ack !== 1'b1 || state !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_set: stray %b state %0d busy %b expected 1 0 0", stray_ack, state, busy);
    end
    tick();
    tick();
    checks++;
    if (stray_ack !== 1'b1) begin
      errors++;
      $display("FAIL stray_sticky: got %b expected 1", stray_ack);
    end
  endtask

  // Sequencer and final report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_hold();
    test_reset_mid_grant();
    test_timeout();
    test_stray_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
